// File: rtl/cam_color_tracker_pkg.sv
// Shared types and pixel-classification helpers for the camera colour tracker.
package cam_track_pkg;

    typedef enum logic [2:0] {
        OP_SCAN    = 3'd0,
        OP_FORWARD = 3'd1,
        OP_LEFT    = 3'd2,
        OP_RIGHT   = 3'd3,
        OP_STOP    = 3'd4
    } op_mode_t;

    typedef enum logic [1:0] {
        COL_RED   = 2'd0,
        COL_GREEN = 2'd1,
        COL_BLUE  = 2'd2,
        COL_WHITE = 2'd3
    } color_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECIDE = 2'd1,
        ST_COMMIT = 2'd2
    } fsm_state_t;

    // Channel classification looks only at the two most significant bits.
    function automatic logic chan_hi(input logic [1:0] top2);
        return &top2;
    endfunction

    function automatic logic chan_lo(input logic [1:0] top2);
        return ~|top2;
    endfunction

endpackage

// File: rtl/cam_color_tracker_if.sv
// Pixel stream in, behaviour decision out. The stream has no backpressure:
// a pixel is taken on every clock edge where in_valid is high; mode_valid is a
// single-cycle strobe and operate_mode is stable whenever it is high and holds after.
interface cam_color_tracker_if #(
    parameter int PIX_W = 12
);
    import cam_track_pkg::*;

    logic             in_valid;
    logic [PIX_W-1:0] in_data;
    logic [1:0]       color_mode;
    op_mode_t         operate_mode;
    logic             mode_valid;
    fsm_state_t       dbg_state;

    modport master (
        output in_valid, in_data, color_mode,
        input  operate_mode, mode_valid, dbg_state
    );

    modport slave (
        input  in_valid, in_data, color_mode,
        output operate_mode, mode_valid, dbg_state
    );

endinterface

// File: rtl/cam_color_match.sv
// Registered colour classifier: one pipeline stage that carries the pixel's
// zone and last-pixel tags alongside the hit flag.
module cam_color_match
    import cam_track_pkg::*;
#(
    parameter int PIX_W = 12,
    parameter int ZN_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [PIX_W-1:0] i_data,
    input  color_sel_t       i_color,
    input  logic [ZN_W-1:0]  i_zone,
    input  logic             i_last,
    output logic             o_hit,
    output logic [ZN_W-1:0]  o_zone,
    output logic             o_last
);
    localparam int C = PIX_W / 3;

    logic [1:0] w_r, w_g, w_b;
    logic       w_hit;
    logic       w_unused_bits;
    logic       r_hit, r_last;
    logic [ZN_W-1:0] r_zone;

    assign w_r = i_data[PIX_W-1 -: 2];
    assign w_g = i_data[2*C-1 -: 2];
    assign w_b = i_data[C-1 -: 2];
    assign w_unused_bits = ^i_data;

    always_comb begin
        w_hit = 1'b0;
        case (i_color)
            COL_RED:   w_hit = chan_hi(w_r) & chan_lo(w_g) & chan_lo(w_b);
            COL_GREEN: w_hit = chan_hi(w_g) & chan_lo(w_r) & chan_lo(w_b);
            COL_BLUE:  w_hit = chan_hi(w_b) & chan_lo(w_r) & chan_lo(w_g);
            COL_WHITE: w_hit = chan_hi(w_r) & chan_hi(w_g) & chan_hi(w_b);
            default:   w_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit  <= 1'b0;
            r_last <= 1'b0;
            r_zone <= '0;
        end else begin
            r_hit  <= i_valid & w_hit;
            r_last <= i_valid & i_last;
            r_zone <= i_zone;
        end
    end

    assign o_hit  = r_hit;
    assign o_last = r_last;
    assign o_zone = r_zone;

endmodule

// File: rtl/cam_color_tracker.sv
// Frame-based colour tracker: per-zone hit histogram, end-of-frame decision FSM.
// Optional hysteresis on the applied behaviour is built when CAM_TRACK_HYST_EN is defined.
module cam_color_tracker
    import cam_track_pkg::*;
#(
    parameter int IMG_W        = 320,
    parameter int IMG_H        = 240,
    parameter int PIX_W        = 12,
    parameter int N_ZONES      = 3,
    parameter int HIT_THRESH   = 64,
    parameter int CLOSE_THRESH = 4096,
    parameter int HYST_FRAMES  = 2
) (
    input  logic clk,
    input  logic reset,
    cam_color_tracker_if.slave bus
);
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int ZN_W   = $clog2(N_ZONES);
    localparam int CNT_W  = $clog2(IMG_W * IMG_H + 1);
    localparam int ZONE_W = IMG_W / N_ZONES;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] ZC_LAST  = COL_W'(ZONE_W - 1);
    localparam logic [ZN_W-1:0]  ZN_LAST  = ZN_W'(N_ZONES - 1);
    localparam logic [ZN_W-1:0]  C_CENTRE = ZN_W'(N_ZONES / 2);

    if (N_ZONES < 3 || (N_ZONES % 2) == 0 || (PIX_W % 3) != 0 || PIX_W < 6 ||
        HYST_FRAMES < 1 || IMG_W < N_ZONES || IMG_H < 1) begin : g_bad_cfg
        $error("cam_color_tracker: unsupported parameter set");
    end

    logic [COL_W-1:0] r_col, r_zcnt;
    logic [ROW_W-1:0] r_row;
    logic [ZN_W-1:0]  r_zone;
    color_sel_t       r_color;
    logic             w_first, w_last;
    color_sel_t       w_color;

    logic             w_m_hit, w_m_last;
    logic [ZN_W-1:0]  w_m_zone;

    logic [CNT_W-1:0] r_cnt  [N_ZONES];
    logic [CNT_W-1:0] r_snap [N_ZONES];

    fsm_state_t       r_state, w_state;
    logic [ZN_W-1:0]  r_idx, w_idx, r_max_idx, w_max_idx;
    logic [CNT_W-1:0] r_max, w_max, r_total, w_total, w_snap_i;
    op_mode_t         r_op, w_op, w_cand;
    logic             r_mode_valid, w_mode_valid;

    assign w_first = (r_col == '0) && (r_row == '0);
    assign w_last  = (r_col == COL_LAST) && (r_row == ROW_LAST);
    // The first pixel of a frame is classified with the colour being latched for it.
    assign w_color = w_first ? color_sel_t'(bus.color_mode) : r_color;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col   <= '0;
            r_row   <= '0;
            r_zone  <= '0;
            r_zcnt  <= '0;
            r_color <= COL_RED;
        end else if (bus.in_valid) begin
            if (w_first) r_color <= color_sel_t'(bus.color_mode);
            if (r_col == COL_LAST) begin
                r_col  <= '0;
                r_zone <= '0;
                r_zcnt <= '0;
                r_row  <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
                // The last zone never advances, so it absorbs the remainder columns.
                if (r_zcnt == ZC_LAST && r_zone != ZN_LAST) begin
                    r_zone <= r_zone + ZN_W'(1);
                    r_zcnt <= '0;
                end else begin
                    r_zcnt <= r_zcnt + COL_W'(1);
                end
            end
        end
    end

    cam_color_match #(
        .PIX_W (PIX_W),
        .ZN_W  (ZN_W)
    ) u_match (
        .clk     (clk),
        .reset   (reset),
        .i_valid (bus.in_valid),
        .i_data  (bus.in_data),
        .i_color (w_color),
        .i_zone  (r_zone),
        .i_last  (w_last),
        .o_hit   (w_m_hit),
        .o_zone  (w_m_zone),
        .o_last  (w_m_last)
    );

    // Snapshot includes the last pixel's own hit; live counters restart at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int z = 0; z < N_ZONES; z++) begin
                r_cnt[z]  <= '0;
                r_snap[z] <= '0;
            end
        end else if (w_m_last) begin
            for (int z = 0; z < N_ZONES; z++) begin
                r_snap[z] <= r_cnt[z] +
                             ((w_m_hit && w_m_zone == ZN_W'(z)) ? CNT_W'(1) : CNT_W'(0));
                r_cnt[z]  <= '0;
            end
        end else if (w_m_hit) begin
            for (int z = 0; z < N_ZONES; z++) begin
                if (w_m_zone == ZN_W'(z)) r_cnt[z] <= r_cnt[z] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_cand = OP_SCAN;
        if (32'(r_total) >= CLOSE_THRESH)   w_cand = OP_STOP;
        else if (32'(r_max) < HIT_THRESH)   w_cand = OP_SCAN;
        else if (r_max_idx == C_CENTRE)     w_cand = OP_FORWARD;
        else if (r_max_idx < C_CENTRE)      w_cand = OP_LEFT;
        else                                w_cand = OP_RIGHT;
    end

`ifdef CAM_TRACK_HYST_EN
    localparam int HC_W = $clog2(HYST_FRAMES + 1);
    op_mode_t        r_prev, w_prev;
    logic [HC_W-1:0] r_agree, w_agree;
`endif

    assign w_snap_i = r_snap[r_idx];

    always_comb begin
        w_state      = r_state;
        w_idx        = r_idx;
        w_max        = r_max;
        w_max_idx    = r_max_idx;
        w_total      = r_total;
        w_op         = r_op;
        w_mode_valid = 1'b0;
`ifdef CAM_TRACK_HYST_EN
        w_prev       = r_prev;
        w_agree      = r_agree;
`endif
        case (r_state)
            ST_DECIDE: begin
                if (r_idx == '0) begin
                    w_max     = w_snap_i;
                    w_max_idx = '0;
                    w_total   = w_snap_i;
                end else begin
                    w_total = r_total + w_snap_i;
                    // Strict '>' keeps the lower index on ties; the centre zone wins ties outright.
                    if (w_snap_i > r_max || (w_snap_i == r_max && r_idx == C_CENTRE)) begin
                        w_max     = w_snap_i;
                        w_max_idx = r_idx;
                    end
                end
                if (r_idx == ZN_LAST) begin
                    w_state = ST_COMMIT;
                    w_idx   = '0;
                end else begin
                    w_idx = r_idx + ZN_W'(1);
                end
            end
            ST_COMMIT: begin
                w_state      = ST_IDLE;
                w_mode_valid = 1'b1;
`ifdef CAM_TRACK_HYST_EN
                if (w_cand == OP_STOP) begin
                    w_prev  = OP_STOP;
                    w_agree = HC_W'(1);
                    w_op    = OP_STOP;
                end else begin
                    if (w_cand == r_prev && r_agree != '0) begin
                        if (r_agree < HC_W'(HYST_FRAMES)) w_agree = r_agree + HC_W'(1);
                    end else begin
                        w_prev  = w_cand;
                        w_agree = HC_W'(1);
                    end
                    if (w_agree >= HC_W'(HYST_FRAMES)) w_op = w_cand;
                end
`else
                w_op = w_cand;
`endif
            end
            default: w_state = ST_IDLE;
        endcase
        // A new frame end abandons whatever decision is still in flight.
        if (w_m_last) begin
            w_state      = ST_DECIDE;
            w_idx        = '0;
            w_op         = r_op;
            w_mode_valid = 1'b0;
`ifdef CAM_TRACK_HYST_EN
            w_prev       = r_prev;
            w_agree      = r_agree;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_max        <= '0;
            r_max_idx    <= '0;
            r_total      <= '0;
            r_op         <= OP_SCAN;
            r_mode_valid <= 1'b0;
`ifdef CAM_TRACK_HYST_EN
            r_prev       <= OP_SCAN;
            r_agree      <= '0;
`endif
        end else begin
            r_state      <= w_state;
            r_idx        <= w_idx;
            r_max        <= w_max;
            r_max_idx    <= w_max_idx;
            r_total      <= w_total;
            r_op         <= w_op;
            r_mode_valid <= w_mode_valid;
`ifdef CAM_TRACK_HYST_EN
            r_prev       <= w_prev;
            r_agree      <= w_agree;
`endif
        end
    end

    assign bus.operate_mode = r_op;
    assign bus.mode_valid   = r_mode_valid;
    assign bus.dbg_state    = r_state;

endmodule
